// File: rtl/mutative_tree_plru.sv
// mutative_tree_plru
// Tree-PLRU replacement state for a cache whose associativity can be changed
// at run time. One (WAYS-1)-bit tree vector is kept per set; the WAYS ways are
// split into groups of 2^assoc_lg ways and the victim is chosen inside the
// group picked by group_sel. Every associativity change (and reset) clears all
// tree state with a one-set-per-cycle sweep, so the storage needs only a single
// write port.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   access_valid/_set/_way   hit or fill completed; update PLRU path of that way
//   lookup_set, group_sel    victim query (group_sel low bits select the group)
//   victim_way, victim_onehot  combinational victim and its way write enables
//   mode_req, mode_lg        associativity change request (held until mode_ack)
//   mode_ack                 one-cycle pulse when the change has completed
//   assoc_lg                 current log2 associativity
//   busy                     clear sweep in progress
module mutative_tree_plru #(
  parameter int WAYS         = 8,
  parameter int SETS         = 16,
  parameter int WAY_IDX_BITS = $clog2(WAYS),
  parameter int SET_IDX_BITS = $clog2(SETS),
  parameter int LG_BITS      = $clog2(WAY_IDX_BITS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    access_valid,
  input  logic [SET_IDX_BITS-1:0] access_set,
  input  logic [WAY_IDX_BITS-1:0] access_way,
  input  logic [SET_IDX_BITS-1:0] lookup_set,
  input  logic [WAY_IDX_BITS-1:0] group_sel,
  output logic [WAY_IDX_BITS-1:0] victim_way,
  output logic [WAYS-1:0]         victim_onehot,
  input  logic                    mode_req,
  input  logic [LG_BITS-1:0]      mode_lg,
  output logic                    mode_ack,
  output logic [LG_BITS-1:0]      assoc_lg,
  output logic                    busy
);

  localparam int W = WAY_IDX_BITS;
  localparam logic [LG_BITS-1:0]      FULL_LG   = LG_BITS'(W);
  localparam logic [SET_IDX_BITS-1:0] LAST_SET  = SET_IDX_BITS'(SETS - 1);
  localparam logic [W-1:0]            WAY_MASK  = W'(WAYS - 1);
  localparam logic [W:0]              ROOT_BASE = (W + 1)'(WAYS);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                  state_reg, state_next;
  logic [SET_IDX_BITS-1:0] clr_cnt_reg, clr_cnt_next;
  logic [LG_BITS-1:0]      assoc_lg_reg, assoc_lg_next;
  logic                    mode_ack_reg, mode_ack_next;
  // Set when the running sweep was started by a mode change (not by reset).
  logic                    ack_pending_reg, ack_pending_next;

  // Heap-indexed node bits 1..WAYS-1 per set.
  logic [WAYS-1:1] plru_mem [SETS];

  logic                    wr_en;
  logic [SET_IDX_BITS-1:0] wr_addr;
  logic [WAYS-1:1]         wr_data;
  logic [LG_BITS-1:0]      mode_clamped;

  // ---------------------------------------------------------------------
  // Access update: node on level gi of the path to access_way is
  // 2^gi + (top gi bits of access_way); it is pointed away from the way.
  // ---------------------------------------------------------------------
  logic [W-1:0] path_node [W];
  logic         path_bit  [W];

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_path
      assign path_node[gi] = W'(1 << gi) | W'(access_way >> (W - gi));
      assign path_bit[gi]  = ~access_way[W-1-gi];
    end
  endgenerate

  logic [WAYS-1:1] access_row;

  always_comb begin
    access_row = plru_mem[access_set];
    for (int l = 0; l < W; l++) begin
      access_row[path_node[l]] = path_bit[l];
    end
  end

  // ---------------------------------------------------------------------
  // Victim walk. victim_acc starts as the group index and shifts in one
  // node bit per level, so after d levels it equals (group << d) | path.
  // During a sweep the bits are forced to 0, giving the group base.
  // ---------------------------------------------------------------------
  logic [WAYS-1:1] lookup_row;
  logic [W-1:0]    group_low;
  logic [W-1:0]    walk_node;
  logic [W-1:0]    victim_acc;
  logic            walk_bit;

  always_comb begin
    lookup_row = plru_mem[lookup_set];
    group_low  = group_sel & (WAY_MASK >> assoc_lg_reg);
    // For d=0 the root wraps to 0 here, but no level is walked then.
    walk_node  = W'(ROOT_BASE >> assoc_lg_reg) | group_low;
    victim_acc = group_low;
    walk_bit   = 1'b0;
    for (int k = 0; k < W; k++) begin
      if (k < int'(assoc_lg_reg)) begin
        walk_bit   = (state_reg == CLEAR) ? 1'b0 : lookup_row[walk_node];
        walk_node  = W'({walk_node, walk_bit});
        victim_acc = W'({victim_acc, walk_bit});
      end
    end
  end

  assign victim_way    = victim_acc;
  assign victim_onehot = {{(WAYS-1){1'b0}}, 1'b1} << victim_acc;

  // ---------------------------------------------------------------------
  // Single write port: the sweep owns it in CLEAR, accesses own it in IDLE.
  // ---------------------------------------------------------------------
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = access_set;
    wr_data = access_row;
    if (!rst) begin
      if (state_reg == CLEAR) begin
        wr_en   = 1'b1;
        wr_addr = clr_cnt_reg;
        wr_data = '0;
      end else if (access_valid) begin
        wr_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      plru_mem[wr_addr] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------
  // Mode / sweep FSM
  // ---------------------------------------------------------------------
  assign mode_clamped = (mode_lg > FULL_LG) ? FULL_LG : mode_lg;

  always_comb begin
    state_next       = state_reg;
    clr_cnt_next     = clr_cnt_reg;
    assoc_lg_next    = assoc_lg_reg;
    mode_ack_next    = 1'b0;
    ack_pending_next = ack_pending_reg;
    case (state_reg)
      IDLE: begin
        // A request still high during the ack cycle is the old one.
        if (mode_req && !mode_ack_reg) begin
          state_next       = CLEAR;
          clr_cnt_next     = '0;
          assoc_lg_next    = mode_clamped;
          ack_pending_next = 1'b1;
        end
      end
      CLEAR: begin
        clr_cnt_next = clr_cnt_reg + 1'b1;
        if (clr_cnt_reg == LAST_SET) begin
          state_next       = IDLE;
          mode_ack_next    = ack_pending_reg;
          ack_pending_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= CLEAR;
      clr_cnt_reg     <= '0;
      assoc_lg_reg    <= FULL_LG;
      mode_ack_reg    <= 1'b0;
      ack_pending_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      clr_cnt_reg     <= clr_cnt_next;
      assoc_lg_reg    <= assoc_lg_next;
      mode_ack_reg    <= mode_ack_next;
      ack_pending_reg <= ack_pending_next;
    end
  end

  assign mode_ack = mode_ack_reg;
  assign assoc_lg = assoc_lg_reg;
  assign busy     = (state_reg == CLEAR);

endmodule
